// File: rtl/i2s_pkg.sv
// Shared constants and types for the I2S slave transceiver.
package i2s_pkg;

    localparam int D_WIDTH       = 24;
    localparam int SCLK_WS_RATIO = 64;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

    // Idle until the first sclk rise, locked until the first ws transition, then running.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOCKED,
        ST_RUN
    } lock_state_e;

endpackage

// File: rtl/i2s_sync.sv
// Two-flop synchronizer for one asynchronous bit, with a registered copy of the
// synchronized value so rising and falling edges can be detected on mclk.
module i2s_sync (
    input  logic mclk,
    input  logic reset_n,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // NOTE: non-blocking assignments, so all three stages shift on the same clock edge.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign q_o    = sync_q;
    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/i2s_slave.sv
// I2S slave transceiver: sclk/ws come from the converter and are oversampled on mclk.
// Optional sticky framing check built when I2S_SLAVE_FRAME_CHECK_EN is defined.
module i2s_slave
    import i2s_pkg::*;
#(
    parameter int d_width       = D_WIDTH,
    parameter int sclk_ws_ratio = SCLK_WS_RATIO
) (
    input  logic               mclk,
    input  logic               reset_n,
    input  logic               sclk,
    input  logic               ws,
    input  logic               sd_rx,
    output logic               sd_tx,
    input  logic [d_width-1:0] l_data_tx,
    input  logic [d_width-1:0] r_data_tx,
    output logic               tx_load,
    output logic [d_width-1:0] l_data_rx,
    output logic [d_width-1:0] r_data_rx,
    output logic               rx_valid,
    output logic               frame_err
);

    localparam int               CNT_W   = $clog2(d_width + 1);
    localparam logic [CNT_W-1:0] BITS    = CNT_W'(d_width);
    localparam logic [CNT_W-1:0] BITS_M1 = CNT_W'(d_width - 1);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic ws_s, ws_rise, ws_fall;
    logic sd_s, sd_rise, sd_fall;

    i2s_sync u_sync_sclk (
        .mclk    (mclk),
        .reset_n (reset_n),
        .d_i     (sclk),
        .q_o     (sclk_lvl),
        .rise_o  (sclk_rise),
        .fall_o  (sclk_fall)
    );

    i2s_sync u_sync_ws (
        .mclk    (mclk),
        .reset_n (reset_n),
        .d_i     (ws),
        .q_o     (ws_s),
        .rise_o  (ws_rise),
        .fall_o  (ws_fall)
    );

    i2s_sync u_sync_sd (
        .mclk    (mclk),
        .reset_n (reset_n),
        .d_i     (sd_rx),
        .q_o     (sd_s),
        .rise_o  (sd_rise),
        .fall_o  (sd_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{sclk_lvl, sclk_fall, ws_rise, ws_fall, sd_rise, sd_fall};

    lock_state_e        state_q,     state_d;
    logic               ws_last_q,   ws_last_d;
    logic [CNT_W-1:0]   bit_cnt_q,   bit_cnt_d;
    logic [d_width-1:0] rx_sh_q,     rx_sh_d;
    logic [d_width-1:0] l_hold_q,    l_hold_d;
    logic               left_ok_q,   left_ok_d;
    logic [d_width-1:0] tx_r_hold_q, tx_r_hold_d;
    logic [d_width-1:0] tx_sh_q,     tx_sh_d;
    logic               sd_tx_q,     sd_tx_d;
    logic [d_width-1:0] l_rx_q,      l_rx_d;
    logic [d_width-1:0] r_rx_q,      r_rx_d;
    logic               rx_valid_q,  rx_valid_d;
    logic               tx_load_q,   tx_load_d;
    logic               slot_start;

    always_comb begin
        // NOTE: every next-state value defaults to its register first, so no latch is inferred.
        state_d     = state_q;
        ws_last_d   = ws_last_q;
        bit_cnt_d   = bit_cnt_q;
        rx_sh_d     = rx_sh_q;
        l_hold_d    = l_hold_q;
        left_ok_d   = left_ok_q;
        tx_r_hold_d = tx_r_hold_q;
        tx_sh_d     = tx_sh_q;
        sd_tx_d     = sd_tx_q;
        l_rx_d      = l_rx_q;
        r_rx_d      = r_rx_q;
        rx_valid_d  = 1'b0;
        tx_load_d   = 1'b0;
        slot_start  = 1'b0;

        if (sclk_rise) begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d   = ST_LOCKED;
                    ws_last_d = ws_s;
                end
                default: begin
                    if (ws_s != ws_last_q) begin
                        slot_start = 1'b1;
                        state_d    = ST_RUN;
                        ws_last_d  = ws_s;
                        bit_cnt_d  = '0;
                        if (ws_s == CH_LEFT) begin
                            // A slot counts only if its start was seen while running.
                            if (state_q == ST_RUN && left_ok_q && bit_cnt_q == BITS) begin
                                l_rx_d     = l_hold_q;
                                r_rx_d     = rx_sh_q;
                                rx_valid_d = 1'b1;
                            end
                            // The left word goes straight into the shifter, which acts as its hold.
                            tx_r_hold_d = r_data_tx;
                            tx_load_d   = 1'b1;
                            tx_sh_d     = l_data_tx;
                        end else begin
                            l_hold_d  = rx_sh_q;
                            left_ok_d = (state_q == ST_RUN) && (bit_cnt_q == BITS);
                            tx_sh_d   = tx_r_hold_q;
                        end
                        sd_tx_d = tx_sh_d[d_width-1];
                    end else if (state_q == ST_RUN) begin
                        if (bit_cnt_q < BITS) begin
                            rx_sh_d   = {rx_sh_q[d_width-2:0], sd_s};
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                        if (bit_cnt_q < BITS_M1) begin
                            tx_sh_d = tx_sh_q << 1;
                            sd_tx_d = tx_sh_q[d_width-2];
                        end else begin
                            sd_tx_d = 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            ws_last_q   <= 1'b0;
            bit_cnt_q   <= '0;
            rx_sh_q     <= '0;
            l_hold_q    <= '0;
            left_ok_q   <= 1'b0;
            tx_r_hold_q <= '0;
            tx_sh_q     <= '0;
            sd_tx_q     <= 1'b0;
            l_rx_q      <= '0;
            r_rx_q      <= '0;
            rx_valid_q  <= 1'b0;
            tx_load_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ws_last_q   <= ws_last_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_sh_q     <= rx_sh_d;
            l_hold_q    <= l_hold_d;
            left_ok_q   <= left_ok_d;
            tx_r_hold_q <= tx_r_hold_d;
            tx_sh_q     <= tx_sh_d;
            sd_tx_q     <= sd_tx_d;
            l_rx_q      <= l_rx_d;
            r_rx_q      <= r_rx_d;
            rx_valid_q  <= rx_valid_d;
            tx_load_q   <= tx_load_d;
        end
    end

    assign sd_tx     = sd_tx_q;
    assign tx_load   = tx_load_q;
    assign rx_valid  = rx_valid_q;
    assign l_data_rx = l_rx_q;
    assign r_data_rx = r_rx_q;

`ifdef I2S_SLAVE_FRAME_CHECK_EN
    localparam int              FC_W       = $clog2(sclk_ws_ratio) + 1;
    localparam logic [FC_W-1:0] HALF_EDGES = FC_W'(sclk_ws_ratio / 2);

    logic [FC_W-1:0] edge_cnt_q;
    logic            frame_err_q;

    // The half in which lock happened is partial, so only halves begun while running are judged.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            edge_cnt_q  <= '0;
            frame_err_q <= 1'b0;
        end else if (sclk_rise && state_q != ST_IDLE) begin
            if (slot_start) begin
                edge_cnt_q <= FC_W'(1);
                if (state_q == ST_RUN && edge_cnt_q != HALF_EDGES) begin
                    frame_err_q <= 1'b1;
                end
            end else if (edge_cnt_q != '1) begin
                edge_cnt_q <= edge_cnt_q + FC_W'(1);
            end
        end
    end

    assign frame_err = frame_err_q;
`else
    localparam int unused_ratio = sclk_ws_ratio;

    assign frame_err = 1'b0;
`endif

endmodule
